shift_add_mult_ctrl: RTL and testbench

// Sequential unsigned multiplier controller that time-shares the existing 6-bit

---
 rtl/shift_add_mult_ctrl.sv | 102 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add unsigned multiplier controller driving a shared external
// WIDTH-bit ripple adder; one adder pass per cycle, WIDTH passes per product.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start, a, b       request and operands, taken only in IDLE or DONE
//   busy, done        busy while iterating; done pulses one cycle with product
//   product           2*WIDTH result, held until the next finished operation
//   adder_x/y/sel     drive the shared adder (x=acc_hi, y=gated mcand, sel=add)
//   adder_sum/cout    combinational result of that adder, same cycle
module shift_add_mult_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   adder_x,
    output logic [WIDTH-1:0]   adder_y,
    output logic               adder_sel,
    input  logic [WIDTH-1:0]   adder_sum,
    input  logic               adder_cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] mcand_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;

    // The adder result is one bit wider than acc_hi (carry out); shifting
    // {cout, sum, mplier} right by one keeps the carry and pushes the
    // finished low bit of the partial sum into the multiplier register.
    assign acc_next    = {adder_cout, adder_sum[WIDTH-1:1]};
    assign mplier_next = {adder_sum[0], mplier_r[WIDTH-1:1]};

    assign adder_x   = acc_hi;
    assign adder_y   = mplier_r[0] ? mcand_r : '0;
    assign adder_sel = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            acc_hi   <= '0;
            mplier_r <= '0;
            mcand_r  <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_hi   <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi   <= acc_next;
                    mplier_r <= mplier_next;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= {acc_next, mplier_next};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: table vectors, random
// operands against a plain a*b model, and multi-cycle corner sequences.
module tb_shift_add_mult_ctrl;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   adder_x;
    logic [W-1:0]   adder_y;
    logic           adder_sel;
    logic [W-1:0]   adder_sum;
    logic           adder_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural model of the shared ripple add/sub unit.
    always_comb begin
        if (adder_sel)
            {adder_cout, adder_sum} = {1'b0, adder_x} - {1'b0, adder_y};
        else
            {adder_cout, adder_sum} = {1'b0, adder_x} + {1'b0, adder_y};
    end

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .adder_x    (adder_x),
        .adder_y    (adder_y),
        .adder_sel  (adder_sel),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive operands with start=1 so the next rising edge is cycle 0.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
    endtask

    // Walk cycles 1..W+1 after an accepted start. glitch (>0) pulses start
    // with junk operands during RUN; hold leaves start asserted at the end.
    task automatic run_check(input string name, input logic [2*W-1:0] exp,
                             input int glitch, input bit hold);
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold)
                start = 1'b0;
            if (cyc <= W) begin
                chk({name, " busy"}, 32'(busy), 32'd1);
                chk({name, " done"}, 32'(done), 32'd0);
                chk({name, " sel"}, 32'(adder_sel), 32'd0);
            end else begin
                chk({name, " done"}, 32'(done), 32'd1);
                chk({name, " busy"}, 32'(busy), 32'd0);
                chk({name, " product"}, 32'(product), 32'(exp));
            end
            if (glitch > 0 && cyc == glitch) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else if (glitch > 0 && cyc == glitch + 1 && !hold) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] held;

        vecs[0] = '{a: 6'd5,  b: 6'd3,  exp: 12'd15};
        vecs[1] = '{a: 6'd63, b: 6'd63, exp: 12'd3969};
        vecs[2] = '{a: 6'd0,  b: 6'd42, exp: 12'd0};
        vecs[3] = '{a: 6'd42, b: 6'd0,  exp: 12'd0};
        vecs[4] = '{a: 6'd1,  b: 6'd1,  exp: 12'd1};
        vecs[5] = '{a: 6'd63, b: 6'd1,  exp: 12'd63};
        vecs[6] = '{a: 6'd1,  b: 6'd63, exp: 12'd63};
        vecs[7] = '{a: 6'd32, b: 6'd33, exp: 12'd1056};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst product", 32'(product), 32'd0);
        chk("rst adder_x", 32'(adder_x), 32'd0);
        chk("rst adder_y", 32'(adder_y), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b);
            run_check($sformatf("vec%0d", i), vecs[i].exp, 0, 1'b0);
        end

        // After the done pulse the controller idles and holds the product.
        held = vecs[7].exp;
        @(negedge clk);
        chk("post done", 32'(done), 32'd0);
        chk("post busy", 32'(busy), 32'd0);
        chk("post product", 32'(product), 32'(held));

        // Start pulsed mid-run with different operands is ignored.
        launch(6'd7, 6'd9);
        run_check("ignore", 12'd63, 3, 1'b0);

        // Random operands, some with ignored mid-run start pulses.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            launch(ra, rb);
            run_check($sformatf("rnd%0d", i), 12'(ra * rb),
                      (i % 3 == 0) ? int'($urandom_range(2, W)) : 0, 1'b0);
        end

        // Asynchronous reset in the middle of an operation.
        launch(6'd10, 6'd10);
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst product", 32'(product), 32'd0);
        chk("midrst adder_x", 32'(adder_x), 32'd0);
        chk("midrst adder_y", 32'(adder_y), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst idle", 32'(busy), 32'd0);
        launch(6'd2, 6'd3);
        run_check("after rst", 12'd6, 0, 1'b0);

        // Start held high across two operations: done at cycles 7 and 14.
        launch(6'd4, 6'd4);
        run_check("b2b first", 12'd16, 0, 1'b1);
        a = 6'd6;
        b = 6'd5;
        run_check("b2b second", 12'd30, 0, 1'b1);
        start = 1'b0;
        @(negedge clk);
        chk("b2b single pulse", 32'(done), 32'd0);
        chk("b2b idle", 32'(busy), 32'd0);
        chk("b2b held", 32'(product), 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
